avalon_master_initiator: RTL and testbench
==========================================

Name: avalon_master_initiator

Overview:
- Avalon-MM master (initiator) for the project's Avalon slave controller; the slave is the responder at the other end of the same interface.
- Accepts one command at a time from local logic over a valid/ready interface: single read, single write, or burst write.
- Drives the Avalon read/write/burst signals, honours waitrequest, collects readdata/response.
- Returns one result per command; a cycle timeout guarantees no hang on a silent slave.

Parameters:
ADDR_W, 11, Avalon word address width
DATA_W, 32, data width
BCNT_W, 10, burstcount width
TIMEOUT, 256, max idle cycles in any wait state before abort (>=2)

Ports:
clk  in  1  clock (all logic rising-edge)
n_rst  in  1  asynchronous, active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  high only in IDLE; command accepted on cmd_valid&&cmd_ready
cmd_op  in  2  00 read, 01 write, 10 burst write, 11 illegal
cmd_addr  in  ADDR_W  target address
cmd_len  in  BCNT_W  burst beats (burst only)
cmd_wdata  in  DATA_W  data for single write
bw_data  in  DATA_W  burst beat data
bw_valid  in  1  burst beat offered
bw_ready  out  1  burst beat taken on bw_valid&&bw_ready
rsp_valid  out  1  one-cycle result pulse
rsp_rdata  out  DATA_W  read data (0 for writes)
rsp_code  out  2  Avalon code: 00 OKAY, 10 SLAVEERROR, 11 DECODEERROR
rsp_timeout  out  1  qualifies rsp_valid: command aborted by timeout
address  out  ADDR_W  Avalon address
read  out  1  Avalon read
write  out  1  Avalon write
beginbursttransfer  out  1  Avalon burst start
burstcount  out  BCNT_W  Avalon burst length
writedata  out  DATA_W  Avalon write data
waitrequest  in  1  slave stall
readdata  in  DATA_W  slave read data
readdatavalid  in  1  read data strobe
writeresponsevalid  in  1  write response strobe
response  in  2  slave response code

Behaviour:
- Reset: state IDLE; all Avalon outputs, rsp_*, bw_ready, counters and holding register 0; cmd_ready 1 from first post-reset cycle. Reset mid-transaction drops read/write/beginbursttransfer immediately; no rsp issued.
- All Avalon outputs registered; request appears the cycle after command acceptance. Command fields latched at acceptance.
- States: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_RESP, BW_DATA, BW_RESP, DONE.
- IDLE: op 00->RD_REQ, 01->WR_REQ, 10 with cmd_len!=0 ->BW_DATA; op 11 or burst len 0 ->DONE with rsp_code 11, no bus activity.
- RD_REQ: read=1, address held; transfer completes on rising edge with waitrequest=0; read drops next cycle ->RD_WAIT. Earliest readdatavalid counted: cycle after completion.
- RD_WAIT: on readdatavalid capture readdata, response ->DONE.
- WR_REQ: write=1, writedata=cmd_wdata, held until waitrequest=0 ->WR_RESP; wait writeresponsevalid, capture response ->DONE.
- BW_DATA: address=cmd_addr, burstcount=cmd_len held whole burst. One-entry beat register; bw_ready = !held || (write && !waitrequest). write=held. beginbursttransfer=1 for exactly one cycle: first cycle write is asserted, regardless of waitrequest. Beat counter loads cmd_len, decrements per accepted beat (write && !waitrequest); at 0 ->BW_RESP. bw_ready 0 once cmd_len beats taken.
- BW_RESP: as WR_RESP, one response per burst.
- DONE: rsp_valid=1 one cycle, ->IDLE; cmd_ready returns next cycle. Back-to-back commands: 1 idle cycle minimum.
- Strobes readdatavalid/writeresponsevalid outside the matching wait state ignored.
- Timeout: counter cleared on entering each non-IDLE state and on every accepted beat; counts while stalled (waitrequest, awaiting response or bw_valid). At TIMEOUT: read/write deassert, ->DONE with rsp_timeout=1, rsp_code=10.
- Slave address checks (legal range 1..0x62B) not duplicated; slave's response code reported verbatim.

Decomposition:
- Package avalon_pkg: op enum, response code constants (OKAY, SLAVEERROR, DECODEERROR), AVL_MAXADDR=11'h62C, width defaults; shared with slave controller.
- Sub-module avalon_wait_timer: clear/enable/expired counter, TIMEOUT parameter.

Test Plan:
- Read 0x010, slave waitrequest 2 cycles, readdatavalid 3 cycles later with 0xDEADBEEF/00 -> read high exactly 3 cycles, rsp_rdata=0xDEADBEEF, rsp_code=00, one rsp_valid pulse.
- Write 0x020 data 0x12345678, no waitrequest, writeresponsevalid response 10 -> write high 1 cycle, rsp_code=10.
- Burst 0x100 len 4, bw_valid gapped, waitrequest on beat 2 -> beginbursttransfer single cycle, burstcount=4, 4 beats in order, one rsp_valid.
- cmd_op=11 and burst len 0 -> no read/write activity, rsp_code=11 after 2 cycles.
- Read with waitrequest stuck high, TIMEOUT=8 -> read drops after 8 stalled cycles, rsp_timeout=1, rsp_code=10.
- n_rst low mid-burst beat 2 -> all Avalon outputs 0 asynchronously, cmd_ready=1 after release, no rsp_valid.

Source files
------------

// File: rtl/avalon_pkg.sv
// Shared Avalon-MM definitions: command opcodes, response codes, FSM
// states and width defaults. The slave controller imports the same package.
package avalon_pkg;

  localparam int ADDR_W_DEF  = 11;
  localparam int DATA_W_DEF  = 32;
  localparam int BCNT_W_DEF  = 10;
  localparam int TIMEOUT_DEF = 256;

  // First word address past the slave's decoded window (legal range 1..0x62B).
  localparam logic [10:0] AVL_MAXADDR = 11'h62C;

  typedef enum logic [1:0] {
    OP_READ    = 2'b00,
    OP_WRITE   = 2'b01,
    OP_BURST   = 2'b10,
    OP_ILLEGAL = 2'b11
  } op_e;

  localparam logic [1:0] RSP_OKAY        = 2'b00;
  localparam logic [1:0] RSP_SLAVEERROR  = 2'b10;
  localparam logic [1:0] RSP_DECODEERROR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_REQ,
    ST_RD_WAIT,
    ST_WR_REQ,
    ST_WR_RESP,
    ST_BW_DATA,
    ST_BW_RESP,
    ST_DONE
  } mi_state_e;

  // A command is rejected locally when the opcode is reserved or when a
  // burst asks for zero beats; neither ever reaches the bus.
  function automatic logic cmd_is_legal(input logic [1:0] op, input logic len_zero);
    return !((op_e'(op) == OP_ILLEGAL) || ((op_e'(op) == OP_BURST) && len_zero));
  endfunction

endpackage

// File: rtl/avalon_master_initiator_if.sv
// Avalon-MM bus between the initiator (master) and the slave controller.
//
// Handshake rules on this bus: a read or write request is offered by the
// master and held stable; it is taken on a rising edge where waitrequest is
// low. readdatavalid and writeresponsevalid are single-cycle strobes from the
// slave that carry readdata/response; they have no back-pressure.
interface avalon_master_initiator_if #(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 32,
  parameter int BCNT_W = 10
);
  logic [ADDR_W-1:0] address;
  logic              read;
  logic              write;
  logic              beginbursttransfer;
  logic [BCNT_W-1:0] burstcount;
  logic [DATA_W-1:0] writedata;
  logic              waitrequest;
  logic [DATA_W-1:0] readdata;
  logic              readdatavalid;
  logic              writeresponsevalid;
  logic [1:0]        response;

  modport master (
    output address, read, write, beginbursttransfer, burstcount, writedata,
    input  waitrequest, readdata, readdatavalid, writeresponsevalid, response
  );

  modport slave (
    input  address, read, write, beginbursttransfer, burstcount, writedata,
    output waitrequest, readdata, readdatavalid, writeresponsevalid, response
  );
endinterface

// File: rtl/avalon_wait_timer.sv
// Stall timer: counts enabled cycles since the last clear and flags when the
// count has reached TIMEOUT-1, i.e. the current enabled cycle is the
// TIMEOUT-th stalled cycle. The owner combines 'expired' with its own enable.
module avalon_wait_timer #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] count;

  // Count stalled cycles, saturating at the limit until cleared.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != LIMIT)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LIMIT);
endmodule

// File: rtl/avalon_master_initiator.sv
// Avalon-MM initiator: takes one local command (read, write or burst write),
// runs it on the Avalon bus honouring waitrequest, collects the slave's
// readdata/response and returns exactly one result per command. A stall
// timer aborts any wait that exceeds TIMEOUT cycles.
//
// Local handshakes: cmd is taken on a rising edge with cmd_valid && cmd_ready,
// burst beats on bw_valid && bw_ready; rsp_valid is a one-cycle pulse with no
// back-pressure. All Avalon outputs are registered.
module avalon_master_initiator
  import avalon_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int BCNT_W  = BCNT_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [BCNT_W-1:0] cmd_len,
  input  logic [DATA_W-1:0] cmd_wdata,
  input  logic [DATA_W-1:0] bw_data,
  input  logic              bw_valid,
  output logic              bw_ready,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [1:0]        rsp_code,
  output logic              rsp_timeout,
  avalon_master_initiator_if.master avl,
  output mi_state_e         dbg_state
);

  mi_state_e state, next_state;

  logic [ADDR_W-1:0] address_q;
  logic              read_q;
  logic              write_q;
  logic              begin_q;
  logic [BCNT_W-1:0] burstcount_q;
  logic [DATA_W-1:0] writedata_q;   // doubles as the one-entry burst beat register

  logic [BCNT_W-1:0] beat_cnt;      // beats still to complete on the bus
  logic [BCNT_W-1:0] accept_left;   // beats still to take from bw_*
  logic              held;          // beat register occupied (== write in a burst)
  logic              held_next;
  logic              started;       // beginbursttransfer already issued

  logic cmd_fire;
  logic bw_fire;
  logic bus_beat;
  logic tmr_clear;
  logic tmr_enable;
  logic tmr_at_limit;
  logic timed_out;

  assign cmd_ready = (state == ST_IDLE);
  assign cmd_fire  = cmd_valid && cmd_ready;
  assign bus_beat  = (state == ST_BW_DATA) && held && !avl.waitrequest;
  assign bw_ready  = (state == ST_BW_DATA) && (accept_left != '0) &&
                     (!held || !avl.waitrequest);
  assign bw_fire   = bw_valid && bw_ready;
  assign timed_out = tmr_enable && tmr_at_limit;
  assign dbg_state = state;

  // Beat register occupancy for the next cycle; forced empty when leaving the burst.
  assign held_next = (next_state == ST_BW_DATA) && (bw_fire || (held && !bus_beat));

  // The wait timer restarts on every state change and on any burst progress.
  assign tmr_clear = (next_state != state) || bus_beat || bw_fire;

  avalon_wait_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .n_rst  (n_rst),
    .clear  (tmr_clear),
    .enable (tmr_enable),
    .expired(tmr_at_limit)
  );

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; tmr_enable marks cycles spent stalled in a wait state.
  always_comb begin
    next_state = state;
    tmr_enable = 1'b0;
    case (state)
      ST_IDLE: begin
        if (cmd_fire) begin
          if (!cmd_is_legal(cmd_op, cmd_len == '0)) begin
            next_state = ST_DONE;
          end else begin
            case (op_e'(cmd_op))
              OP_READ:  next_state = ST_RD_REQ;
              OP_WRITE: next_state = ST_WR_REQ;
              default:  next_state = ST_BW_DATA;
            endcase
          end
        end
      end
      ST_RD_REQ: begin
        if (!avl.waitrequest) begin
          next_state = ST_RD_WAIT;
        end else begin
          tmr_enable = 1'b1;
          if (tmr_at_limit) next_state = ST_DONE;
        end
      end
      ST_RD_WAIT: begin
        if (avl.readdatavalid) begin
          next_state = ST_DONE;
        end else begin
          tmr_enable = 1'b1;
          if (tmr_at_limit) next_state = ST_DONE;
        end
      end
      ST_WR_REQ: begin
        if (!avl.waitrequest) begin
          next_state = ST_WR_RESP;
        end else begin
          tmr_enable = 1'b1;
          if (tmr_at_limit) next_state = ST_DONE;
        end
      end
      ST_WR_RESP, ST_BW_RESP: begin
        if (avl.writeresponsevalid) begin
          next_state = ST_DONE;
        end else begin
          tmr_enable = 1'b1;
          if (tmr_at_limit) next_state = ST_DONE;
        end
      end
      ST_BW_DATA: begin
        if (bus_beat && (beat_cnt == BCNT_W'(1))) begin
          next_state = ST_BW_RESP;
        end else if (!bus_beat && !bw_fire) begin
          tmr_enable = 1'b1;
          if (tmr_at_limit) next_state = ST_DONE;
        end
      end
      ST_DONE: next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Registered Avalon outputs, burst bookkeeping and result capture.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      address_q    <= '0;
      read_q       <= 1'b0;
      write_q      <= 1'b0;
      begin_q      <= 1'b0;
      burstcount_q <= '0;
      writedata_q  <= '0;
      beat_cnt     <= '0;
      accept_left  <= '0;
      held         <= 1'b0;
      started      <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_code     <= RSP_OKAY;
      rsp_timeout  <= 1'b0;
    end else begin
      read_q    <= (next_state == ST_RD_REQ);
      write_q   <= (next_state == ST_WR_REQ) || held_next;
      begin_q   <= held_next && !started;
      held      <= held_next;
      rsp_valid <= (next_state == ST_DONE);
      if (held_next) started <= 1'b1;
      if (timed_out) begin
        rsp_timeout <= 1'b1;
        rsp_code    <= RSP_SLAVEERROR;
      end
      case (state)
        ST_IDLE: begin
          if (cmd_fire) begin
            address_q    <= cmd_addr;
            burstcount_q <= (op_e'(cmd_op) == OP_BURST) ? cmd_len : BCNT_W'(1);
            writedata_q  <= cmd_wdata;
            beat_cnt     <= cmd_len;
            accept_left  <= cmd_len;
            started      <= 1'b0;
            rsp_rdata    <= '0;
            rsp_timeout  <= 1'b0;
            rsp_code     <= cmd_is_legal(cmd_op, cmd_len == '0) ? RSP_OKAY : RSP_DECODEERROR;
          end
        end
        ST_RD_WAIT: begin
          if (avl.readdatavalid) begin
            rsp_rdata <= avl.readdata;
            rsp_code  <= avl.response;
          end
        end
        ST_WR_RESP, ST_BW_RESP: begin
          if (avl.writeresponsevalid) rsp_code <= avl.response;
        end
        ST_BW_DATA: begin
          if (bw_fire) begin
            writedata_q <= bw_data;
            accept_left <= accept_left - 1'b1;
          end
          if (bus_beat) beat_cnt <= beat_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign avl.address            = address_q;
  assign avl.read               = read_q;
  assign avl.write              = write_q;
  assign avl.beginbursttransfer = begin_q;
  assign avl.burstcount         = burstcount_q;
  assign avl.writedata          = writedata_q;

endmodule

// File: tb/tb_avalon_master_initiator.sv
// Bench for avalon_master_initiator: table of single-command vectors against a
// scripted slave, plus hand-written burst and mid-burst reset sequences.
module tb_avalon_master_initiator;
  import avalon_pkg::*;

  localparam int ADDR_W  = 11;
  localparam int DATA_W  = 32;
  localparam int BCNT_W  = 10;
  localparam int TIMEOUT = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic n_rst = 1'b0;
  always #5 clk = ~clk;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [BCNT_W-1:0] cmd_len;
  logic [DATA_W-1:0] cmd_wdata;
  logic [DATA_W-1:0] bw_data;
  logic              bw_valid;
  logic              bw_ready;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_code;
  logic              rsp_timeout;
  mi_state_e         dbg_state;

  avalon_master_initiator_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BCNT_W(BCNT_W)) avl();

  avalon_master_initiator #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BCNT_W(BCNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .n_rst(n_rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_wdata(cmd_wdata),
    .bw_data(bw_data), .bw_valid(bw_valid), .bw_ready(bw_ready),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_code(rsp_code),
    .rsp_timeout(rsp_timeout), .avl(avl), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int tests = 0;
  int failed = 0;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] got_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [1:0]  op;
    logic [10:0] addr;
    logic [9:0]  len;
    logic [31:0] wdata;
    int          wait_n;   // waitrequest-high cycles before the request is taken
    int          lat;      // strobe this many cycles after completion (0 = never)
    logic [31:0] rdata;
    logic [1:0]  resp;
    logic        stray;    // fire strobes during the request phase too
    int          exp_rd;   // cycles read is high
    int          exp_wr;   // cycles write is high
    int          exp_cyc;  // cycle of rsp_valid after the accepting edge
    logic [1:0]  exp_code;
    logic [31:0] exp_rdata;
    logic        exp_to;
  } vec_t;

  function automatic vec_t mk(input logic [1:0] op, input logic [10:0] addr, input logic [9:0] len,
                              input logic [31:0] wdata, input int wait_n, input int lat,
                              input logic [31:0] rdata, input logic [1:0] resp, input logic stray,
                              input int exp_rd, input int exp_wr, input int exp_cyc,
                              input logic [1:0] exp_code, input logic [31:0] exp_rdata,
                              input logic exp_to);
    vec_t v;
    v.op = op; v.addr = addr; v.len = len; v.wdata = wdata; v.wait_n = wait_n; v.lat = lat;
    v.rdata = rdata; v.resp = resp; v.stray = stray; v.exp_rd = exp_rd; v.exp_wr = exp_wr;
    v.exp_cyc = exp_cyc; v.exp_code = exp_code; v.exp_rdata = exp_rdata; v.exp_to = exp_to;
    return v;
  endfunction

  vec_t vecs[9];

  // ---------------- driver tasks ----------------
  task automatic slave_idle();
    avl.waitrequest        = 1'b0;
    avl.readdatavalid      = 1'b0;
    avl.writeresponsevalid = 1'b0;
    avl.readdata           = 32'hBAD0_0000;
    avl.response           = 2'b01;
  endtask

  // Present a command at a negedge; returns once the next posedge will accept it.
  task automatic offer_cmd(input string name, input logic [1:0] op, input logic [10:0] addr,
                           input logic [9:0] len, input logic [31:0] wdata);
    int guard;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_len = len; cmd_wdata = wdata;
    guard = 0;
    while (!cmd_ready && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 10) check({name, "_cmd_ready_timeout"}, 32'(cmd_ready), 32'd1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int rd_hi = 0, wr_hi = 0, bbt = 0, pulses = 0, rsp_cyc = 0;
    int addr_bad = 0, wd_bad = 0, req_seen = 0, pend = 0;
    logic [1:0] code = 2'b00;
    logic [31:0] rdata = '0;
    logic to = 1'b0;
    string n = $sformatf("v%0d", idx);
    offer_cmd(n, v.op, v.addr, v.len, v.wdata);
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      if (c == 1) cmd_valid = 1'b0;
      if (avl.read) rd_hi++;
      if (avl.write) begin
        wr_hi++;
        if (avl.writedata !== v.wdata) wd_bad++;
      end
      if ((avl.read || avl.write) && (avl.address !== v.addr)) addr_bad++;
      if (avl.beginbursttransfer) bbt++;
      if (rsp_valid) begin
        pulses++; rsp_cyc = c; code = rsp_code; rdata = rsp_rdata; to = rsp_timeout;
      end
      slave_idle();
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          avl.readdatavalid      = (v.op == 2'b00);
          avl.writeresponsevalid = (v.op == 2'b01);
          avl.readdata           = v.rdata;
          avl.response           = v.resp;
        end
      end
      if (avl.read || avl.write) begin
        avl.waitrequest = (req_seen < v.wait_n);
        req_seen++;
        if (!avl.waitrequest && v.lat > 0) pend = v.lat;
        if (v.stray) begin
          avl.readdatavalid = 1'b1;
          avl.writeresponsevalid = 1'b1;
        end
      end
    end
    slave_idle();
    check({n, "_read_cycles"}, 32'(rd_hi), 32'(v.exp_rd));
    check({n, "_write_cycles"}, 32'(wr_hi), 32'(v.exp_wr));
    check({n, "_rsp_pulses"}, 32'(pulses), 32'd1);
    check({n, "_rsp_cycle"}, 32'(rsp_cyc), 32'(v.exp_cyc));
    check({n, "_rsp_code"}, 32'(code), 32'(v.exp_code));
    check({n, "_rsp_rdata"}, rdata, v.exp_rdata);
    check({n, "_rsp_timeout"}, 32'(to), 32'(v.exp_to));
    check({n, "_addr_bad"}, 32'(addr_bad), 32'd0);
    check({n, "_wdata_bad"}, 32'(wd_bad), 32'd0);
    check({n, "_bbt"}, 32'(bbt), 32'd0);
  endtask

  // Burst of 4 at 0x100, beats offered every other cycle, beat 2 stalled twice.
  task automatic run_burst();
    int wr_cyc = 0, rd_hi = 0, bbt = 0, bbt_bad = 0, bad = 0, pulses = 0;
    int offer = 0, stall = 0, pend = 0;
    logic [1:0] code = 2'b11;
    exp_q.delete();
    got_q.delete();
    for (int i = 0; i < 4; i++) exp_q.push_back(32'hB000_0000 + 32'(i));
    offer_cmd("burst", 2'b10, 11'h100, 10'd4, 32'h0);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1) cmd_valid = 1'b0;
      if (avl.write) begin
        wr_cyc++;
        if (avl.burstcount !== 10'd4 || avl.address !== 11'h100) bad++;
      end
      if (avl.read) rd_hi++;
      if (avl.beginbursttransfer) begin
        bbt++;
        if (!avl.write || wr_cyc != 1) bbt_bad++;
      end
      if (rsp_valid) begin
        pulses++; code = rsp_code;
      end
      slave_idle();
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          avl.writeresponsevalid = 1'b1;
          avl.response = 2'b00;
        end
      end
      if (avl.write && got_q.size() == 1 && stall < 2) begin
        avl.waitrequest = 1'b1;
        stall++;
      end
      if (avl.write && !avl.waitrequest) begin
        got_q.push_back(avl.writedata);
        if (got_q.size() == 4) pend = 2;
      end
      bw_valid = (c % 2 == 0) && (offer < 4);
      bw_data  = 32'hB000_0000 + 32'(offer);
      #1;
      if (bw_valid && bw_ready) offer++;
    end
    bw_valid = 1'b0;
    slave_idle();
    check("burst_beats", 32'(got_q.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < got_q.size()) check($sformatf("burst_beat%0d", i), got_q[i], exp_q[i]);
    end
    check("burst_offered", 32'(offer), 32'd4);
    check("burst_bbt_count", 32'(bbt), 32'd1);
    check("burst_bbt_first_write", 32'(bbt_bad), 32'd0);
    check("burst_addr_count_bad", 32'(bad), 32'd0);
    check("burst_write_cycles", 32'(wr_cyc), 32'd6);
    check("burst_read_cycles", 32'(rd_hi), 32'd0);
    check("burst_rsp_pulses", 32'(pulses), 32'd1);
    check("burst_rsp_code", 32'(code), 32'd0);
  endtask

  // Reset asserted asynchronously while the second burst beat is on the bus.
  task automatic run_reset_mid_burst();
    int done_cnt = 0, offer = 0, pulses = 0, not_ready = 0;
    logic hit = 1'b0;
    offer_cmd("rst", 2'b10, 11'h200, 10'd4, 32'h0);
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) cmd_valid = 1'b0;
      slave_idle();
      if (avl.write && done_cnt == 1) begin
        avl.waitrequest = 1'b1;
        hit = 1'b1;
        break;
      end
      if (avl.write) done_cnt++;
      bw_valid = (offer < 4);
      bw_data  = 32'hC000_0000 + 32'(offer);
      #1;
      if (bw_valid && bw_ready) offer++;
    end
    check("rst_reached_beat2", 32'(hit), 32'd1);
    bw_valid = 1'b0;
    #2 n_rst = 1'b0;
    #1;
    check("rst_read", 32'(avl.read), 32'd0);
    check("rst_write", 32'(avl.write), 32'd0);
    check("rst_bbt", 32'(avl.beginbursttransfer), 32'd0);
    check("rst_address", 32'(avl.address), 32'd0);
    check("rst_burstcount", 32'(avl.burstcount), 32'd0);
    check("rst_writedata", avl.writedata, 32'd0);
    check("rst_bw_ready", 32'(bw_ready), 32'd0);
    check("rst_state", 32'(dbg_state), 32'(ST_IDLE));
    slave_idle();
    @(negedge clk);
    n_rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (rsp_valid) pulses++;
      if (!cmd_ready) not_ready++;
    end
    check("rst_no_rsp", 32'(pulses), 32'd0);
    check("rst_cmd_ready_low_cycles", 32'(not_ready), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    //            op     addr     len    wdata          wait lat rdata          resp  stray rd wr cyc code   rdata          to
    vecs[0] = mk(2'b00, 11'h010, 10'd0, 32'h0,         2,    3, 32'hDEADBEEF, 2'b00, 1'b1, 3, 0, 7,  2'b00, 32'hDEADBEEF, 1'b0);
    vecs[1] = mk(2'b01, 11'h020, 10'd0, 32'h12345678,  0,    1, 32'h0,        2'b10, 1'b0, 0, 1, 3,  2'b10, 32'h0,        1'b0);
    vecs[2] = mk(2'b11, 11'h030, 10'd0, 32'h0,         0,    1, 32'h0,        2'b00, 1'b0, 0, 0, 1,  2'b11, 32'h0,        1'b0);
    vecs[3] = mk(2'b10, 11'h040, 10'd0, 32'h0,         0,    1, 32'h0,        2'b00, 1'b0, 0, 0, 1,  2'b11, 32'h0,        1'b0);
    vecs[4] = mk(2'b00, 11'h030, 10'd0, 32'h0,         1000, 0, 32'h0,        2'b00, 1'b0, 8, 0, 9,  2'b10, 32'h0,        1'b1);
    vecs[5] = mk(2'b00, 11'h62B, 10'd0, 32'h0,         0,    1, 32'hA5A50F0F, 2'b11, 1'b0, 1, 0, 3,  2'b11, 32'hA5A50F0F, 1'b0);
    vecs[6] = mk(2'b01, 11'h040, 10'd0, 32'hCAFEF00D,  3,    2, 32'h0,        2'b00, 1'b1, 0, 4, 7,  2'b00, 32'h0,        1'b0);
    vecs[7] = mk(2'b01, 11'h050, 10'd0, 32'h11112222,  0,    0, 32'h0,        2'b00, 1'b0, 0, 1, 10, 2'b10, 32'h0,        1'b1);
    vecs[8] = mk(2'b00, 11'h060, 10'd0, 32'h0,         0,    0, 32'h0,        2'b00, 1'b0, 1, 0, 10, 2'b10, 32'h0,        1'b1);

    cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_len = '0; cmd_wdata = '0;
    bw_data = '0; bw_valid = 1'b0;
    slave_idle();

    // Reset state
    #12;
    check("reset_read", 32'(avl.read), 32'd0);
    check("reset_write", 32'(avl.write), 32'd0);
    check("reset_bbt", 32'(avl.beginbursttransfer), 32'd0);
    check("reset_address", 32'(avl.address), 32'd0);
    check("reset_burstcount", 32'(avl.burstcount), 32'd0);
    check("reset_writedata", avl.writedata, 32'd0);
    check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
    check("reset_rsp_rdata", rsp_rdata, 32'd0);
    check("reset_rsp_code", 32'(rsp_code), 32'd0);
    check("reset_rsp_timeout", 32'(rsp_timeout), 32'd0);
    check("reset_bw_ready", 32'(bw_ready), 32'd0);
    check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
    @(negedge clk);
    n_rst = 1'b1;
    @(negedge clk);
    check("post_reset_cmd_ready", 32'(cmd_ready), 32'd1);

    for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);
    run_burst();
    run_reset_mid_burst();
    run_vec(5, vecs[5]);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
